// File: rtl/md5_pad.sv
// md5_pad: MD5 message padder and single 16-word block buffer.
//
// Collects 32-bit message words into a 512-bit block, appends the MD5
// padding (0x80 byte, zero fill, 64-bit little-endian bit length) and streams
// each block to the MD5 control block one word per cycle, one block per
// low-to-high cycle of ctl_rdy_i.
//
// Build option: define MD5_PAD_EN to enable the padding and length logic.
// Without it the caller must supply pre-padded blocks; a misplaced last word
// raises err_o and the partial block is dropped.
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   in_vld_i / in_rdy_o     input word handshake
//   in_data_i               message word, byte0 in the least significant byte
//   in_last_i, in_nb_i      final word marker and its valid byte count (0..4)
//   ctl_rdy_i               control block is waiting for a new block
//   out_word_o, out_vld_o   block word stream, 16 consecutive strobes
//   done_o                  pulse after the final block of a message is sent
//   err_o                   sticky misuse flag (MD5_PAD_EN undefined only)
module md5_pad (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        in_vld_i,
   output logic        in_rdy_o,
   input  logic [0:31] in_data_i,
   input  logic        in_last_i,
   input  logic [0:2]  in_nb_i,
   input  logic        ctl_rdy_i,
   output logic [0:31] out_word_o,
   output logic        out_vld_o,
   output logic        done_o,
   output logic        err_o
);

   typedef enum logic [1:0] {S_FILL, S_PAD, S_WAIT, S_SEND} state_t;

   state_t      state_q, state_d;
   logic [3:0]  widx_q, widx_d;
   logic [3:0]  ridx_q, ridx_d;
   logic        final_q, final_d;
   logic        armed_q, armed_d;
   logic        in_rdy_q, in_rdy_d;
   logic        out_vld_q, out_vld_d;
   logic [31:0] out_word_q, out_word_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] buf_q [16];
   logic        wr_en;
   logic [31:0] wr_data;

   // Port bit order is ascending; a whole-vector copy keeps the numeric value.
   logic [31:0] din;
   logic [2:0]  nb_in, nb_eff;
   assign din   = in_data_i;
   assign nb_in = in_nb_i;

   // Non-last words are always full; counts above 4 saturate.
   always_comb begin
      nb_eff = 3'd4;
      if (in_last_i && nb_in < 3'd4) nb_eff = nb_in;
   end

`ifdef MD5_PAD_EN
   logic [63:0] bitcnt_q, bitcnt_d;
   logic        pend80_q, pend80_d;
   logic        padpend_q, padpend_d;
   logic        fit_q, fit_d;    // 0x80 landed at or below slot 13 of this block
   logic [31:0] last_word;

   // Last word: keep bytes below nb, place 0x80 at byte nb, zero the rest.
   always_comb begin
      last_word = 32'd0;
      for (int k = 0; k < 4; k++) begin
         if (k < int'(nb_eff))       last_word[8*k +: 8] = din[8*k +: 8];
         else if (k == int'(nb_eff)) last_word[8*k +: 8] = 8'h80;
      end
   end
`endif

   // NOTE: combinational logic uses blocking assignments and assigns every
   // output a default first, so no path can leave a latch behind.
   always_comb begin
      state_d    = state_q;
      widx_d     = widx_q;
      ridx_d     = ridx_q;
      final_d    = final_q;
      err_d      = err_q;
      out_vld_d  = 1'b0;
      out_word_d = 32'd0;
      done_d     = 1'b0;
      wr_en      = 1'b0;
      wr_data    = 32'd0;
`ifdef MD5_PAD_EN
      bitcnt_d   = bitcnt_q;
      pend80_d   = pend80_q;
      padpend_d  = padpend_q;
      fit_d      = fit_q;
`endif
      // A sent block stays consumed until the control block drops ready.
      armed_d = armed_q;
      if (state_q == S_WAIT && ctl_rdy_i && armed_q) armed_d = 1'b0;
      else if (!ctl_rdy_i)                           armed_d = 1'b1;

      case (state_q)
         S_FILL: begin
            if (in_vld_i) begin
               wr_en  = 1'b1;
               widx_d = widx_q + 4'd1;
`ifdef MD5_PAD_EN
               wr_data  = in_last_i ? last_word : din;
               bitcnt_d = bitcnt_q + {58'd0, nb_eff, 3'd0};
               if (in_last_i) begin
                  pend80_d = (nb_eff == 3'd4);
                  fit_d    = 1'b0;
                  if (widx_q == 4'd15) begin
                     state_d   = S_WAIT;
                     padpend_d = 1'b1;
                  end else begin
                     state_d = S_PAD;
                  end
               end else if (widx_q == 4'd15) begin
                  state_d = S_WAIT;
               end
`else
               wr_data = din;
               if (in_last_i) begin
                  if (widx_q == 4'd15 && nb_eff == 3'd4) begin
                     state_d = S_WAIT;
                     final_d = 1'b1;
                  end else begin
                     // Misplaced end of message: drop the partial block.
                     err_d  = 1'b1;
                     widx_d = 4'd0;
                  end
               end else if (widx_q == 4'd15) begin
                  state_d = S_WAIT;
               end
`endif
            end
         end

         S_PAD: begin
`ifdef MD5_PAD_EN
            wr_en    = 1'b1;
            widx_d   = widx_q + 4'd1;
            pend80_d = 1'b0;
            wr_data  = pend80_q ? 32'h0000_0080 : 32'd0;
            if (widx_q == 4'd14) begin
               // Length goes in 14/15 only if the 0x80 is already behind us.
               fit_d = !pend80_q;
               if (!pend80_q) wr_data = bitcnt_q[31:0];
            end else if (widx_q == 4'd15) begin
               state_d = S_WAIT;
               if (fit_q) begin
                  wr_data = bitcnt_q[63:32];
                  final_d = 1'b1;
               end else begin
                  padpend_d = 1'b1;
               end
            end
`else
            state_d = S_FILL;
`endif
         end

         S_WAIT: begin
            if (ctl_rdy_i && armed_q) begin
               state_d    = S_SEND;
               out_vld_d  = 1'b1;
               out_word_d = buf_q[0];
               ridx_d     = 4'd1;
            end
         end

         S_SEND: begin
            // ridx wraps to 0 once word 15 is on the output.
            if (ridx_q != 4'd0) begin
               out_vld_d  = 1'b1;
               out_word_d = buf_q[ridx_q];
               ridx_d     = ridx_q + 4'd1;
            end else begin
               widx_d  = 4'd0;
               state_d = S_FILL;
`ifdef MD5_PAD_EN
               if (padpend_q) begin
                  padpend_d = 1'b0;
                  state_d   = S_PAD;
               end else if (final_q) begin
                  done_d   = 1'b1;
                  final_d  = 1'b0;
                  bitcnt_d = 64'd0;
               end
`else
               if (final_q) begin
                  done_d  = 1'b1;
                  final_d = 1'b0;
               end
`endif
            end
         end
      endcase

      in_rdy_d = (state_d == S_FILL);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_FILL;
         widx_q     <= 4'd0;
         ridx_q     <= 4'd0;
         final_q    <= 1'b0;
         armed_q    <= 1'b1;
         in_rdy_q   <= 1'b1;
         out_vld_q  <= 1'b0;
         out_word_q <= 32'd0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef MD5_PAD_EN
         bitcnt_q   <= 64'd0;
         pend80_q   <= 1'b0;
         padpend_q  <= 1'b0;
         fit_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         widx_q     <= widx_d;
         ridx_q     <= ridx_d;
         final_q    <= final_d;
         armed_q    <= armed_d;
         in_rdy_q   <= in_rdy_d;
         out_vld_q  <= out_vld_d;
         out_word_q <= out_word_d;
         done_q     <= done_d;
         err_q      <= err_d;
`ifdef MD5_PAD_EN
         bitcnt_q   <= bitcnt_d;
         pend80_q   <= pend80_d;
         padpend_q  <= padpend_d;
         fit_q      <= fit_d;
`endif
      end
   end

   // NOTE: the block buffer has no reset; every slot is rewritten before a
   // block can be sent, so stale contents are never observed.
   always_ff @(posedge clk_i) begin
      if (wr_en) buf_q[widx_q] <= wr_data;
   end

   assign in_rdy_o   = in_rdy_q;
   assign out_vld_o  = out_vld_q;
   assign out_word_o = out_word_q;
   assign done_o     = done_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_md5_pad.sv
// tb_md5_pad: directed self-checking bench for md5_pad. Covers the padding
// build when MD5_PAD_EN is defined and the pre-padded build otherwise.
module tb_md5_pad;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_vld = 1'b0;
   logic        in_last = 1'b0;
   logic        ctl_rdy = 1'b0;
   logic [31:0] in_data = 32'd0;
   logic [2:0]  in_nb = 3'd0;
   logic        in_rdy, out_vld, done, err;
   logic [31:0] out_word;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int vld_cnt = 0;
   int d0, v0;
   logic [31:0] got [16];
   logic [31:0] exp_blk [16];

   md5_pad dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .in_vld_i   (in_vld),
      .in_rdy_o   (in_rdy),
      .in_data_i  (in_data),
      .in_last_i  (in_last),
      .in_nb_i    (in_nb),
      .ctl_rdy_i  (ctl_rdy),
      .out_word_o (out_word),
      .out_vld_o  (out_vld),
      .done_o     (done),
      .err_o      (err)
   );

   always #5 clk = ~clk;

   // Values seen here are those held through the cycle that just ended.
   always @(posedge clk) begin
      if (done)    done_cnt++;
      if (out_vld) vld_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      total++;
      if (obs !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, want);
      end
   endtask

   function automatic logic [31:0] pat(input int i);
      return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
   endfunction

   // Called at a negedge; returns at the negedge after the transfer edge.
   task automatic put(input logic [31:0] d, input logic last, input logic [2:0] nb);
      int t = 0;
      while (!in_rdy && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_rdy) check("put_rdy_timeout", in_rdy, 1'b1);
      in_vld = 1'b1; in_data = d; in_last = last; in_nb = nb;
      @(negedge clk);
      in_vld = 1'b0; in_last = 1'b0; in_nb = 3'd0;
   endtask

   // Raise ctl_rdy, capture one 16-word block, optionally drop ctl_rdy after.
   task automatic collect(input bit drop);
      int  t = 0;
      bit  run_ok = 1'b1;
      for (int i = 0; i < 16; i++) got[i] = 32'hDEAD_BEEF;
      ctl_rdy = 1'b1;
      while (!out_vld && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("vld_start", out_vld, 1'b1);
      if (out_vld) begin
         for (int i = 0; i < 16; i++) begin
            if (!out_vld) run_ok = 1'b0;
            got[i] = out_word;
            @(negedge clk);
         end
         check("vld_run16", run_ok, 1'b1);
         check("vld_end", out_vld, 1'b0);
      end
      if (drop) ctl_rdy = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic exp_clear();
      for (int i = 0; i < 16; i++) exp_blk[i] = 32'd0;
   endtask

   task automatic check_block(input string tag);
      for (int i = 0; i < 16; i++)
         check($sformatf("%s_w%0d", tag, i), got[i], exp_blk[i]);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_in_rdy", in_rdy, 1'b1);
      check("rst_out_vld", out_vld, 1'b0);
      check("rst_out_word", out_word, 32'd0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef MD5_PAD_EN
      // Empty message.
      d0 = done_cnt;
      put(32'd0, 1'b1, 3'd0);
      collect(1'b1);
      exp_clear(); exp_blk[0] = 32'h0000_0080;
      check_block("empty");
      check("empty_done", done_cnt - d0, 1);

      // "abc": 24 bits.
      d0 = done_cnt;
      put(32'h0063_6261, 1'b1, 3'd3);
      collect(1'b1);
      exp_clear(); exp_blk[0] = 32'h8063_6261; exp_blk[14] = 32'h0000_0018;
      check_block("abc");
      check("abc_done", done_cnt - d0, 1);

      // nb=7 saturates to a full word: 32 bits, 0x80 in the next slot.
      put(32'h4433_2211, 1'b1, 3'd7);
      collect(1'b1);
      exp_clear(); exp_blk[0] = 32'h4433_2211; exp_blk[1] = 32'h0000_0080;
      exp_blk[14] = 32'h0000_0020;
      check_block("nb7");

      // 14 full words: 0x80 at slot 14 forces a second, length-only block.
      d0 = done_cnt;
      for (int i = 0; i < 14; i++) put(pat(i), i == 13, 3'd4);
      collect(1'b1);
      exp_clear();
      for (int i = 0; i < 14; i++) exp_blk[i] = pat(i);
      exp_blk[14] = 32'h0000_0080;
      check_block("w14a");
      check("w14a_no_done", done_cnt - d0, 0);
      collect(1'b1);
      exp_clear(); exp_blk[14] = 32'h0000_01C0;
      check_block("w14b");
      check("w14b_done", done_cnt - d0, 1);

      // 15 full words with ctl_rdy held high: block 2 waits for a re-arm.
      d0 = done_cnt;
      for (int i = 0; i < 15; i++) put(pat(i + 20), i == 14, 3'd4);
      collect(1'b0);
      exp_clear();
      for (int i = 0; i < 15; i++) exp_blk[i] = pat(i + 20);
      exp_blk[15] = 32'h0000_0080;
      check_block("pace_a");
      v0 = vld_cnt;
      repeat (40) @(negedge clk);
      check("pace_held_vld", vld_cnt - v0, 0);
      check("pace_held_done", done_cnt - d0, 0);
      ctl_rdy = 1'b0;
      @(negedge clk);
      collect(1'b1);
      exp_clear(); exp_blk[14] = 32'h0000_01E0;
      check_block("pace_b");
      check("pace_done", done_cnt - d0, 1);

      // Reset at widx=7: partial block discarded, bit count restarts.
      for (int i = 0; i < 7; i++) put(pat(i + 40), 1'b0, 3'd4);
      rst_n = 1'b0;
      #1;
      check("mrst_in_rdy", in_rdy, 1'b1);
      check("mrst_out_vld", out_vld, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      d0 = done_cnt;
      put(32'h0063_6261, 1'b1, 3'd3);
      collect(1'b1);
      exp_clear(); exp_blk[0] = 32'h8063_6261; exp_blk[14] = 32'h0000_0018;
      check_block("mrst_abc");
      check("mrst_done", done_cnt - d0, 1);
`else
      // Pre-padded single block.
      d0 = done_cnt;
      for (int i = 0; i < 16; i++) put(pat(i), i == 15, 3'd4);
      collect(1'b1);
      for (int i = 0; i < 16; i++) exp_blk[i] = pat(i);
      check_block("blk");
      check("blk_done", done_cnt - d0, 1);

      // Two blocks, ctl_rdy held: block B waits for a re-arm.
      d0 = done_cnt;
      for (int i = 0; i < 16; i++) put(pat(i + 20), 1'b0, 3'd4);
      collect(1'b0);
      for (int i = 0; i < 16; i++) exp_blk[i] = pat(i + 20);
      check_block("pace_a");
      check("pace_a_no_done", done_cnt - d0, 0);
      for (int i = 0; i < 16; i++) put(pat(i + 40), i == 15, 3'd4);
      v0 = vld_cnt;
      repeat (20) @(negedge clk);
      check("pace_held_vld", vld_cnt - v0, 0);
      check("pace_stall", in_rdy, 1'b0);
      ctl_rdy = 1'b0;
      @(negedge clk);
      collect(1'b1);
      for (int i = 0; i < 16; i++) exp_blk[i] = pat(i + 40);
      check_block("pace_b");
      check("pace_b_done", done_cnt - d0, 1);

      // Last at widx=5: error, partial block dropped.
      for (int i = 0; i < 6; i++) put(pat(i + 60), i == 5, 3'd4);
      v0 = vld_cnt;
      ctl_rdy = 1'b1;
      repeat (40) @(negedge clk);
      ctl_rdy = 1'b0;
      check("err_set", err, 1'b1);
      check("err_no_send", vld_cnt - v0, 0);
      check("err_in_rdy", in_rdy, 1'b1);
      for (int i = 0; i < 16; i++) put(pat(i + 80), i == 15, 3'd4);
      collect(1'b1);
      for (int i = 0; i < 16; i++) exp_blk[i] = pat(i + 80);
      check_block("after_err");
      check("err_sticky", err, 1'b1);

      // Reset at widx=7 clears the error and the partial block.
      for (int i = 0; i < 7; i++) put(pat(i + 100), 1'b0, 3'd4);
      rst_n = 1'b0;
      #1;
      check("mrst_in_rdy", in_rdy, 1'b1);
      check("mrst_out_vld", out_vld, 1'b0);
      check("mrst_err", err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 16; i++) put(pat(i + 120), i == 15, 3'd4);
      collect(1'b1);
      for (int i = 0; i < 16; i++) exp_blk[i] = pat(i + 120);
      check_block("mrst_blk");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
